// File: rtl/flag_checker_pkg.sv
// Shared constants and helpers for the flag checker.
// Result bit positions are fixed here so the top and any consumer agree on the layout.
package flag_checker_pkg;

  localparam logic [7:0] DEF_SEED = 8'hA5;
  localparam logic [7:0] DEF_TAPS = 8'hB8;

  localparam int RES_PASS    = 0;
  localparam int RES_DONE    = 1;
  localparam int RES_ERR_LSB = 2;

  // Widest string the byte helper can address; flags are zero-extended to this.
  localparam int MAX_FLAG_BYTES = 64;
  localparam int FLAG_EXT_W     = 8 * MAX_FLAG_BYTES;

  // Byte idx of an nbytes-long string, byte 0 being the most significant.
  // An idx past the end shifts everything out and yields 0.
  function automatic logic [7:0] flag_byte(input logic [FLAG_EXT_W-1:0] vec,
                                           input int unsigned nbytes,
                                           input int unsigned idx);
    logic [FLAG_EXT_W-1:0] sh;
    sh = vec >> (8 * (nbytes - 1 - idx));
    return sh[7:0];
  endfunction

endpackage

// File: rtl/flag_checker_if.sv
// Candidate-string input and checker outputs grouped as one bundle.
// The checker connects through the slave modport; the driver of flag uses master.
interface flag_checker_if #(
  parameter int FLAG_BYTES = 24
);
  logic [8*FLAG_BYTES-1:0] flag;
  logic [7:0]              key;
  logic [7:0]              enc_byte;
  logic                    enc_valid;
  logic [7:0]              result;
  logic                    pass;

  modport master (output flag, input key, enc_byte, enc_valid, result, pass);
  modport slave  (input flag, output key, enc_byte, enc_valid, result, pass);
endinterface

// File: rtl/flag_checker_keygen.sv
// 8-bit Galois LFSR keystream generator with enable and synchronous active-low reset.
// A zero SEED would lock the register at zero, so it is replaced by 8'h01.
module flag_checker_keygen
  import flag_checker_pkg::*;
#(
  parameter logic [7:0] SEED = DEF_SEED,
  parameter logic [7:0] TAPS = DEF_TAPS
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_en,
  output logic [7:0] o_key
);

  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

  logic [7:0] r_lfsr;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_lfsr <= SEED_EFF;
    end else if (i_en) begin
      r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : 8'h00);
    end
  end

  assign o_key = r_lfsr;

endmodule

// File: rtl/flag_checker.sv
// Streaming flag checker: encrypts the candidate one byte per clock and validates it
// against the encrypted golden string. Optional macro FLAGCHK_ERRCNT_EN adds a live mismatch count.
module flag_checker
  import flag_checker_pkg::*;
#(
  parameter int                      FLAG_BYTES = 24,
  parameter logic [7:0]              SEED       = DEF_SEED,
  parameter logic [7:0]              TAPS       = DEF_TAPS,
  parameter logic [8*FLAG_BYTES-1:0] GOLDEN     = "shc2024{verilog_is_fun!}"
) (
  input  logic           i_clk,
  input  logic           i_reset,
  flag_checker_if.slave  bus
);

  localparam int IDX_W = $clog2(FLAG_BYTES + 1);
  localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(FLAG_BYTES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FLAG_BYTES - 1);
  localparam logic [FLAG_EXT_W-1:0] GOLDEN_EXT = FLAG_EXT_W'(GOLDEN);

  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_enc_byte;
  logic             r_enc_valid;
  logic [IDX_W-1:0] r_vidx;
  logic             r_mismatch;
  logic             r_done;
  logic             r_pass;

  logic             w_counting;
  logic [7:0]       w_key;
  logic [7:0]       w_vkey;
  logic [7:0]       w_plain;
  logic [7:0]       w_exp;
  logic             w_byte_bad;
  logic [5:0]       w_err_cnt;
  logic [7:0]       w_result;

  assign w_counting = (r_idx != IDX_END);

  flag_checker_keygen #(.SEED(SEED), .TAPS(TAPS)) u_enc_key (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (w_counting),
    .o_key   (w_key)
  );

  // Validator keystream steps only on accepted bytes, so it stays in lockstep with the encoder.
  flag_checker_keygen #(.SEED(SEED), .TAPS(TAPS)) u_val_key (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (r_enc_valid),
    .o_key   (w_vkey)
  );

  assign w_plain = flag_byte(FLAG_EXT_W'(bus.flag), FLAG_BYTES, 32'(r_idx));

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_idx       <= '0;
      r_enc_byte  <= 8'h00;
      r_enc_valid <= 1'b0;
    end else if (w_counting) begin
      r_idx       <= r_idx + IDX_W'(1);
      r_enc_byte  <= w_plain ^ w_key;
      r_enc_valid <= 1'b1;
    end else begin
      r_enc_valid <= 1'b0;
    end
  end

  assign w_exp      = flag_byte(GOLDEN_EXT, FLAG_BYTES, 32'(r_vidx)) ^ w_vkey;
  assign w_byte_bad = r_enc_valid && (r_enc_byte != w_exp);

  // The verdict folds in the last byte's own compare, which is not yet in r_mismatch.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_vidx     <= '0;
      r_mismatch <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
    end else if (r_enc_valid) begin
      r_vidx <= r_vidx + IDX_W'(1);
      if (w_byte_bad) begin
        r_mismatch <= 1'b1;
      end
      if (r_vidx == IDX_LAST) begin
        r_done <= 1'b1;
        r_pass <= ~(r_mismatch | w_byte_bad);
      end
    end
  end

`ifdef FLAGCHK_ERRCNT_EN
  logic [5:0] r_err_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_err_cnt <= 6'd0;
    end else if (w_byte_bad && (r_err_cnt != 6'h3F)) begin
      r_err_cnt <= r_err_cnt + 6'd1;
    end
  end

  assign w_err_cnt = r_err_cnt;
`else
  assign w_err_cnt = 6'd0;
`endif

  always_comb begin
    w_result                     = 8'h00;
    w_result[RES_PASS]           = r_pass & r_done;
    w_result[RES_DONE]           = r_done;
    w_result[RES_ERR_LSB +: 6]   = w_err_cnt;
  end

  assign bus.key       = w_key;
  assign bus.enc_byte  = r_enc_byte;
  assign bus.enc_valid = r_enc_valid;
  assign bus.result    = w_result;
  assign bus.pass      = w_result[RES_PASS];

endmodule

// File: tb/tb_flag_checker.sv
// Scoreboard bench for flag_checker: stimulus queues expected bytes and verdicts,
// a negedge monitor pops and compares them whenever the DUT presents output.
module tb_flag_checker;

  localparam int NB = 24;
  localparam logic [8*NB-1:0] S_GOLD  = "shc2024{verilog_is_fun!}";
  localparam logic [8*NB-1:0] S_WRONG = "shc2024{this_is_wrooong}";
  localparam logic [8*NB-1:0] S_LAST  = "shc2024{verilog_is_fun!!";
  localparam logic [8*NB-1:0] S_JUNK  = "XXXXXXXXXXXXXXXXXXXXXXXX";

`ifdef FLAGCHK_ERRCNT_EN
  localparam logic [7:0] EXP_WRONG = 8'h36;
  localparam logic [7:0] EXP_LAST  = 8'h06;
`else
  localparam logic [7:0] EXP_WRONG = 8'h02;
  localparam logic [7:0] EXP_LAST  = 8'h02;
`endif
  localparam logic [7:0] EXP_PASS = 8'h03;

  typedef struct {
    logic [7:0] enc;
    logic [7:0] key;
  } enc_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  enc_exp_t   q_enc[$];
  logic [7:0] q_res[$];

  int   n_valid = 0;
  bit   prev_done = 1'b0;
  bit   zero_seen = 1'b0;
  logic [7:0] last_key;
  logic [7:0] last_enc;

  always #5 clk = ~clk;

  flag_checker_if #(.FLAG_BYTES(NB)) bus ();
  flag_checker_if #(.FLAG_BYTES(NB)) bus0 ();

  flag_checker dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  flag_checker #(.SEED(8'h00)) dut0 (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus0)
  );

  function automatic logic [7:0] lfsr_next(input logic [7:0] k);
    return (k >> 1) ^ (k[0] ? 8'hB8 : 8'h00);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      n_valid   = 0;
      prev_done = 1'b0;
    end else begin
      if (bus0.key == 8'h00) zero_seen = 1'b1;
      if (bus.enc_valid) begin
        n_valid++;
        if (q_enc.size() == 0) begin
          chk("enc_unexpected", 32'(bus.enc_byte), 32'hFFFF_FFFF);
        end else begin
          enc_exp_t e;
          e = q_enc.pop_front();
          chk("enc_byte", 32'(bus.enc_byte), 32'(e.enc));
          chk("key", 32'(bus.key), 32'(e.key));
        end
      end
      if (bus.result[1] && !prev_done) begin
        if (q_res.size() == 0) begin
          chk("result_unexpected", 32'(bus.result), 32'hFFFF_FFFF);
        end else begin
          logic [7:0] r;
          r = q_res.pop_front();
          chk("result", 32'(bus.result), 32'(r));
          chk("pass_pin", 32'(bus.pass), 32'(r[0]));
        end
        chk("valid_count", n_valid, NB);
      end
      prev_done = bus.result[1];
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    q_enc.delete();
    q_res.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_key", 32'(bus.key), 32'hA5);
    chk("rst_enc_byte", 32'(bus.enc_byte), 32'h00);
    chk("rst_enc_valid", 32'(bus.enc_valid), 32'h0);
    chk("rst_result", 32'(bus.result), 32'h00);
    chk("rst_seed0_key", 32'(bus0.key), 32'h01);
  endtask

  // abort_at > 0: pull out after that many cycles, with no verdict expected.
  task automatic run(input logic [8*NB-1:0] f, input logic [7:0] exp_res,
                     input bit hand, input int abort_at);
    logic [7:0] k;
    enc_exp_t e;
    int cyc;
    bit got;
    bus.flag  = f;
    bus0.flag = f;
    do_reset();
    k = 8'hA5;
    for (int i = 0; i < NB; i++) begin
      e.enc = f[8*(NB-1-i) +: 8] ^ k;
      k = lfsr_next(k);
      e.key = k;
      q_enc.push_back(e);
    end
    last_key = k;
    last_enc = e.enc;
    if (abort_at == 0) q_res.push_back(exp_res);
    rst_n = 1'b1;
    cyc = 0;
    got = 1'b0;
    while (cyc < 40 && !got) begin
      @(posedge clk);
      #1;
      cyc++;
      if (hand && cyc == 1) begin
        chk("hand_enc0", 32'(bus.enc_byte), 32'hD6);
        chk("hand_key1", 32'(bus.key), 32'hEA);
        chk("hand_seed0_key1", 32'(bus0.key), 32'hB8);
      end
      if (hand && cyc == 2) begin
        chk("hand_enc1", 32'(bus.enc_byte), 32'h82);
        chk("hand_key2", 32'(bus.key), 32'h75);
        chk("hand_seed0_key2", 32'(bus0.key), 32'h5C);
      end
      if (abort_at != 0 && cyc == abort_at) begin
        chk("abort_no_done", 32'(bus.result[1]), 32'h0);
        return;
      end
      if (bus.result[1]) got = 1'b1;
    end
    chk("done_latency", got ? cyc : -1, 25);
    if (hand) chk("seed0_result", 32'(bus0.result), 32'(EXP_PASS));
    @(negedge clk);
    #1;
  endtask

  task automatic freeze_check();
    bus.flag = S_JUNK;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("frz_enc_valid", 32'(bus.enc_valid), 32'h0);
      chk("frz_key", 32'(bus.key), 32'(last_key));
      chk("frz_enc_byte", 32'(bus.enc_byte), 32'(last_enc));
      chk("frz_result", 32'(bus.result), 32'(EXP_PASS));
    end
  endtask

  initial begin
    bus.flag  = S_GOLD;
    bus0.flag = S_GOLD;
    run(S_GOLD, EXP_PASS, 1'b1, 0);
    freeze_check();
    run(S_WRONG, EXP_WRONG, 1'b0, 0);
    run(S_LAST, EXP_LAST, 1'b0, 0);
    run(S_GOLD, EXP_PASS, 1'b0, 10);
    run(S_GOLD, EXP_PASS, 1'b1, 0);
    freeze_check();
    chk("seed0_never_zero", 32'(zero_seen), 32'h0);
    chk("scoreboard_drained", q_enc.size() + q_res.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
